// File: rtl/strobe_timer_scheduler_pkg.sv
`default_nettype none
// strobe_sched_pkg: shared tick-index, mode and arbiter-state definitions for the strobe timer scheduler.
// Revision: 1.0

package strobe_sched_pkg;

   localparam logic [1:0] TICK_1MS   = 2'd0;
   localparam logic [1:0] TICK_16MS  = 2'd1;
   localparam logic [1:0] TICK_125MS = 2'd2;
   localparam logic [1:0] TICK_1S    = 2'd3;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/strobe_timer_scheduler_channel.sv
`default_nettype none
// timer_channel: one countdown channel with reload, Active, Pending and sticky Overrun state.
// Revision: 1.0

module timer_channel
   import strobe_sched_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [3:0]       tick_i,
   input  logic             cfg_wr_i,
   input  logic             cfg_en_i,
   input  logic             cfg_periodic_i,
   input  logic [1:0]       cfg_base_i,
   input  logic [CNT_W-1:0] cfg_load_i,
   input  logic             ack_i,
   input  logic             ovr_clr_i,
   output logic             active_o,
   output logic             pending_o,
   output logic             overrun_o
);

   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] load_q, load_d;
   logic             mode_q, mode_d;
   logic [1:0]       base_q, base_d;
   logic             active_q, active_d;
   logic             pending_q, pending_d;
   logic             overrun_q, overrun_d;

   logic [CNT_W-1:0] w_load;
   logic             w_tick_hit;
   logic             w_expire;

   // A zero load would never expire; treat it as "expire on the next tick".
   assign w_load     = (cfg_load_i == '0) ? CNT_W'(1) : cfg_load_i;
   assign w_tick_hit = active_q && tick_i[base_q] && !cfg_wr_i;
   assign w_expire   = w_tick_hit && (count_q == CNT_W'(1));

   always_comb begin
      count_d   = count_q;
      load_d    = load_q;
      mode_d    = mode_q;
      base_d    = base_q;
      active_d  = active_q;
      pending_d = pending_q;
      overrun_d = overrun_q;

      if (cfg_wr_i) begin
         pending_d = 1'b0;
         if (cfg_en_i) begin
            active_d = 1'b1;
            count_d  = w_load;
            load_d   = w_load;
            mode_d   = cfg_periodic_i ? MODE_PERIODIC : MODE_ONESHOT;
            base_d   = cfg_base_i;
         end else begin
            active_d = 1'b0;
         end
      end else if (w_expire) begin
         pending_d = 1'b1;
         if (mode_q == MODE_PERIODIC) begin
            count_d = load_q;
         end else begin
            active_d = 1'b0;
         end
      end else begin
         if (w_tick_hit) begin
            count_d = count_q - CNT_W'(1);
         end
         if (ack_i) begin
            pending_d = 1'b0;
         end
      end

      // A re-expiry that coincides with the ack of the previous event is not an overrun.
      if (w_expire && pending_q && !ack_i) begin
         overrun_d = 1'b1;
      end else if (ovr_clr_i) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q   <= '0;
         load_q    <= '0;
         mode_q    <= MODE_ONESHOT;
         base_q    <= 2'd0;
         active_q  <= 1'b0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         load_q    <= load_d;
         mode_q    <= mode_d;
         base_q    <= base_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign active_o  = active_q;
   assign pending_o = pending_q;
   assign overrun_o = overrun_q;

endmodule

`default_nettype wire

// File: rtl/strobe_timer_scheduler.sv
`default_nettype none
// strobe_timer_scheduler: NUM_CH strobe-driven countdown channels serialized onto one valid/ack event port.
// Revision: 1.0

module strobe_timer_scheduler
   import strobe_sched_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8
) (
   input  logic                      LpcClock,
   input  logic                      Reset,
   input  logic [3:0]                Tick,
   input  logic                      CfgWr,
   input  logic [$clog2(NUM_CH)-1:0] CfgCh,
   input  logic                      CfgEn,
   input  logic                      CfgPeriodic,
   input  logic [1:0]                CfgBase,
   input  logic [CNT_W-1:0]          CfgLoad,
   output logic                      EvtValid,
   output logic [$clog2(NUM_CH)-1:0] EvtCh,
   input  logic                      EvtAck,
   output logic [NUM_CH-1:0]         Active,
   output logic [NUM_CH-1:0]         Overrun,
   input  logic                      OvrClr
);

   localparam int CH_W = $clog2(NUM_CH);

   arb_state_e      state_q;
   logic [CH_W-1:0] ptr_q;
   logic [CH_W-1:0] evt_ch_q;
   logic            evt_valid_q;

   logic [NUM_CH-1:0] w_pending;
   logic [NUM_CH-1:0] w_ack;
   logic [CH_W-1:0]   w_sel;

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
         assign w_ack[g] = (state_q == ARB_BUSY) && EvtAck && (evt_ch_q == CH_W'(g));

         timer_channel #(
            .CNT_W(CNT_W)
         ) u_channel (
            .clk_i         (LpcClock),
            .rst_i         (Reset),
            .tick_i        (Tick),
            .cfg_wr_i      (CfgWr && (CfgCh == CH_W'(g))),
            .cfg_en_i      (CfgEn),
            .cfg_periodic_i(CfgPeriodic),
            .cfg_base_i    (CfgBase),
            .cfg_load_i    (CfgLoad),
            .ack_i         (w_ack[g]),
            .ovr_clr_i     (OvrClr),
            .active_o      (Active[g]),
            .pending_o     (w_pending[g]),
            .overrun_o     (Overrun[g])
         );
      end
   endgenerate

   // Walk from the farthest candidate back toward Ptr+1 so the nearest pending channel wins.
   always_comb begin
      w_sel = '0;
      for (int i = NUM_CH; i >= 1; i--) begin
         if (w_pending[(int'(ptr_q) + i) % NUM_CH]) begin
            w_sel = CH_W'((int'(ptr_q) + i) % NUM_CH);
         end
      end
   end

   always_ff @(posedge LpcClock or posedge Reset) begin
      if (Reset) begin
         state_q     <= ARB_IDLE;
         ptr_q       <= CH_W'(NUM_CH - 1);
         evt_ch_q    <= '0;
         evt_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (|w_pending) begin
                  evt_ch_q    <= w_sel;
                  evt_valid_q <= 1'b1;
                  state_q     <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (EvtAck) begin
                  ptr_q       <= evt_ch_q;
                  evt_valid_q <= 1'b0;
                  state_q     <= ARB_IDLE;
               end
            end
            default: begin
               evt_valid_q <= 1'b0;
               state_q     <= ARB_IDLE;
            end
         endcase
      end
   end

   assign EvtValid = evt_valid_q;
   assign EvtCh    = evt_ch_q;

endmodule

`default_nettype wire
